// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath types for the multicycle divider
package cpu_pkg;

  // Divider control states, in the order the sequence walks through them
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Cycles from the div_start cycle to the div_done cycle (full sequence)
  localparam int DIV_LATENCY = 35;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           spill;

  // Shift the next dividend bit in, then subtract the divisor if it fits.
  // The remainder stays below the divisor, so the bit shifted out of the
  // window is always zero; if it were set the value would exceed any divisor.
  always_comb begin
    spill   = rem_in[WIDTH];
    shifted = {rem_in[WIDTH-1:0], dvd_msb};
    diff    = shifted - {1'b0, divisor};
    q_bit   = spill | (shifted >= {1'b0, divisor});
    rem_out = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed divider (quotient on lo, remainder on hi); option DIV_ZERO_EARLY_EN
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             div_start,
  input  logic [WIDTH-1:0] entrada_a,
  input  logic [WIDTH-1:0] entrada_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_busy,
  output logic             div_done,
  output logic             div_zero
);

  div_state_t state;
  div_state_t next_state;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   partial_rem;
  logic [WIDTH-1:0] dvd_shift;    // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] divisor_abs;
  logic             sign_q;
  logic             sign_r;
  logic             zero_div;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] q_signed;
  logic [WIDTH-1:0] r_signed;
  logic             b_is_zero;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (partial_rem),
    .dvd_msb(dvd_shift[WIDTH-1]),
    .divisor(divisor_abs),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  // Operand magnitudes and signed results; the most negative value maps to itself modulo 2^WIDTH
  always_comb begin
    a_abs     = entrada_a[WIDTH-1] ? ('0 - entrada_a) : entrada_a;
    b_abs     = entrada_b[WIDTH-1] ? ('0 - entrada_b) : entrada_b;
    b_is_zero = (entrada_b == '0);
    q_signed  = sign_q ? ('0 - dvd_shift) : dvd_shift;
    r_signed  = sign_r ? ('0 - partial_rem[WIDTH-1:0]) : partial_rem[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; div_start only matters in IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (div_start) next_state = LOAD;
`ifdef DIV_ZERO_EARLY_EN
      LOAD: next_state = b_is_zero ? DONE : CALC;
`else
      LOAD: next_state = CALC;
`endif
      CALC: if (cnt == CNT_W'(1)) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    div_busy = (state == LOAD) || (state == CALC) || (state == FIX);
    div_done = (state == DONE);
  end

  // Datapath: latch operands in LOAD, one restoring step per CALC cycle, publish results in FIX
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      partial_rem <= '0;
      dvd_shift   <= '0;
      divisor_abs <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_div    <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_zero    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          partial_rem <= '0;
          dvd_shift   <= a_abs;
          divisor_abs <= b_abs;
          sign_q      <= entrada_a[WIDTH-1] ^ entrada_b[WIDTH-1];
          sign_r      <= entrada_a[WIDTH-1];
          zero_div    <= b_is_zero;
          cnt         <= CNT_W'(WIDTH);
`ifdef DIV_ZERO_EARLY_EN
          // The shortcut skips FIX, so the forced zero result is published here
          if (b_is_zero) begin
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b1;
          end
`endif
        end
        CALC: begin
          partial_rem <= step_rem;
          dvd_shift   <= {dvd_shift[WIDTH-2:0], step_q};
          cnt         <= cnt - 1'b1;
        end
        FIX: begin
          hi       <= zero_div ? '0 : r_signed;
          lo       <= zero_div ? '0 : q_signed;
          div_zero <= zero_div;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit (table, hand sequences, random vs reference)
module tb_div_unit;
  import cpu_pkg::*;

  logic  clk = 1'b0;
  logic  reset_n;
  logic  div_start;
  word_t entrada_a;
  word_t entrada_b;
  word_t hi;
  word_t lo;
  logic  div_busy;
  logic  div_done;
  logic  div_zero;

  always #5 clk = ~clk;

  div_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .div_start(div_start),
    .entrada_a(entrada_a),
    .entrada_b(entrada_b),
    .hi       (hi),
    .lo       (lo),
    .div_busy (div_busy),
    .div_done (div_done),
    .div_zero (div_zero)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    word_t lo;
    word_t hi;
    bit    zero;
  } res_t;

  typedef struct {
    word_t a;
    word_t b;
    word_t lo;
    word_t hi;
    bit    zero;
  } vec_t;

  res_t cap_res;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MIPS div: truncating quotient, remainder carries the dividend's sign, zero divisor forces 0/0
  function automatic res_t ref_div(input word_t a, input word_t b);
    res_t   r;
    longint la;
    longint lb;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (b == 32'd0) begin
      r.lo = '0;
      r.hi = '0;
      r.zero = 1'b1;
    end else begin
      r.lo = word_t'(la / lb);
      r.hi = word_t'(la % lb);
      r.zero = 1'b0;
    end
    return r;
  endfunction

  function automatic int lat(input word_t b);
`ifdef DIV_ZERO_EARLY_EN
    if (b == 32'd0) return 2;
`endif
    return DIV_LATENCY;
  endfunction

  // Called just after a rising edge; cycle 0 is the cycle the first start is driven in.
  // Extra starts s2/s3 (ascending, -1 = none) carry operands a2/b2.
  task automatic run(input word_t a, input word_t b, input int s2, input word_t a2, input word_t b2,
                     input int s3, input int ncyc, input string tag);
    logic [127:0] busy_act, done_act, busy_exp, done_exp;
    word_t lo_log[128];
    word_t hi_log[128];
    bit    z_log[128];
    int    starts[3];
    word_t sb[3];
    word_t sa[3];
    int    nf;
    int    d;
    bit    first;
    res_t  r;
    res_t  last;
    busy_act = '0;
    done_act = '0;
    for (int c = 0; c < ncyc; c++) begin
      div_start = (c == 0) || (c == s2) || (c == s3);
      if (c <= 1) begin
        entrada_a = a;
        entrada_b = b;
      end else if ((s2 >= 0 && (c == s2 || c == s2 + 1)) || (s3 >= 0 && (c == s3 || c == s3 + 1))) begin
        entrada_a = a2;
        entrada_b = b2;
      end else begin
        entrada_a = $urandom;
        entrada_b = $urandom;
      end
      @(negedge clk);
      busy_act[c] = div_busy;
      done_act[c] = div_done;
      lo_log[c] = lo;
      hi_log[c] = hi;
      z_log[c] = div_zero;
      @(posedge clk);
      #1;
    end
    div_start = 1'b0;
    starts[0] = 0;  sa[0] = a;  sb[0] = b;
    starts[1] = s2; sa[1] = a2; sb[1] = b2;
    starts[2] = s3; sa[2] = a2; sb[2] = b2;
    busy_exp = '0;
    done_exp = '0;
    nf = 0;
    first = 1'b1;
    last = cap_res;
    for (int k = 0; k < 3; k++) begin
      if (starts[k] >= 0 && starts[k] >= nf) begin
        d = starts[k] + lat(sb[k]);
        for (int j = starts[k] + 1; j < d; j++) busy_exp[j] = 1'b1;
        done_exp[d] = 1'b1;
        r = ref_div(sa[k], sb[k]);
        if (d < ncyc) begin
          chk({tag, "_lo"}, lo_log[d], r.lo);
          chk({tag, "_hi"}, hi_log[d], r.hi);
          chk({tag, "_zero"}, z_log[d], r.zero);
          if (first) begin
            cap_res.lo = lo_log[d];
            cap_res.hi = hi_log[d];
            cap_res.zero = z_log[d];
            first = 1'b0;
          end
          last = r;
        end
        nf = d + 1;
      end
    end
    chk({tag, "_busy_mask"}, busy_act, busy_exp);
    chk({tag, "_done_mask"}, done_act, done_exp);
    chk({tag, "_hold"}, {hi_log[ncyc-1], lo_log[ncyc-1]}, {last.hi, last.lo});
  endtask

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic done_seen;
    logic busy_seen;
    word_t ra;
    word_t rb;

    tbl[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1] = '{32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    tbl[3] = '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    tbl[4] = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tbl[5] = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
    tbl[6] = '{32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF,  32'd0,          1'b0};
    tbl[7] = '{32'd123,        32'd0,          32'd0,          32'd0,          1'b1};

    cap_res = '{32'd0, 32'd0, 1'b0};
    reset_n = 1'b0;
    div_start = 1'b0;
    entrada_a = '0;
    entrada_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {hi, lo, div_busy, div_done, div_zero}, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      run(tbl[i].a, tbl[i].b, -1, '0, '0, -1, 37, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_result", i), {cap_res.hi, cap_res.lo, cap_res.zero},
          {tbl[i].hi, tbl[i].lo, tbl[i].zero});
    end

    // Start while busy (cycle 5) and during DONE (cycle 35) are both ignored
    run(32'd100, 32'd7, 5, 32'd9, 32'd3, 35, 40, "busy_start");
    chk("busy_start_result", {cap_res.hi, cap_res.lo}, {32'd2, 32'd14});

    // Start in DONE ignored, start in the following IDLE cycle accepted
    run(32'd100, 32'd7, 35, 32'hFFFF_FFE7, 32'd4, 36, 74, "back_to_back");

    // Reset mid-operation: results hold from the previous op, then reset clears everything
    run(32'd100, 32'd7, -1, '0, '0, -1, 37, "pre_rst");
    div_start = 1'b1;
    entrada_a = 32'hFFFF_FFF9;
    entrada_b = 32'd2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 9) chk("hold_during_op", {hi, lo}, {32'd2, 32'd14});
      @(posedge clk);
      #1;
      div_start = 1'b0;
    end
    reset_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_op_reset", {hi, lo, div_busy, div_done, div_zero}, '0);
    done_seen = 1'b0;
    busy_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      done_seen |= div_done;
      busy_seen |= div_busy;
    end
    chk("no_done_after_reset", {done_seen, busy_seen}, 2'b00);
    @(posedge clk);
    #1;

    // Randomized operands against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          rb = word_t'($urandom_range(1, 15));
          if ($urandom_range(0, 1) == 1) rb = '0 - rb;
        end
        1: rb = '0;
        default: rb = $urandom;
      endcase
      run(ra, rb, -1, '0, '0, -1, 37, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
